// File: rtl/booth_pkg.sv
// booth_pkg: shared state, digit encoding and latency helper for the radix-4 Booth multiplier
package booth_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } digit_t;
  function automatic int iter_count(int width);
    return width / 2 + 1;
  endfunction
endpackage

// File: rtl/booth_r4_encoder.sv
// booth_r4_encoder: maps a 3-bit multiplier group to a signed digit in {-2,-1,0,+1,+2}
module booth_r4_encoder
  import booth_pkg::*;
(
  input  logic [2:0] grp,
  output digit_t     dig
);
  always_comb begin
    dig.neg = grp[2] & ~(grp[1] & grp[0]);
    dig.one = grp[1] ^ grp[0];
    dig.two = (grp == 3'b011) | (grp == 3'b100);
  end
endmodule

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-4 Booth multiplier, two multiplier bits per clock
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int E = WIDTH + 2;
  localparam int L = iter_count(WIDTH);
  localparam int CW = $clog2(L + 1);
  state_t state, state_nx;
  logic [E:0] acc, mag, sum, acc_nx;
  logic [E-1:0] m, q, q_nx, a_ext, b_ext;
  logic qm1, last, accept;
  logic [CW-1:0] cnt;
  digit_t dig;
  booth_r4_encoder u_enc (
    .grp({q[1:0], qm1}),
    .dig(dig)
  );
  // E-bit operands plus an E+1-bit accumulator keep +/-2A and the unsigned MSB exact
  always_comb begin
    a_ext  = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
    b_ext  = signed_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
    mag    = dig.two ? {m, 1'b0} : dig.one ? {m[E-1], m} : '0;
    sum    = dig.neg ? acc - mag : acc + mag;
    acc_nx = {{2{sum[E]}}, sum[E:2]};
    q_nx   = {sum[1:0], q[E-1:2]};
    last   = cnt == CW'(L - 1);
    accept = start & ~abort & (state != RUN);
  end
  always_comb begin
    state_nx = abort ? IDLE : (state == RUN) ? (last ? DONE : RUN) : start ? RUN : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      qm1     <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      m   <= a_ext;
      acc <= '0;
      q   <= b_ext;
      qm1 <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      acc <= acc_nx;
      q   <= q_nx;
      qm1 <= q[1];
      cnt <= cnt + 1'b1;
      if (last && !abort) product <= {acc_nx[WIDTH-3:0], q_nx};
    end
  assign busy = state == RUN;
  assign done = state == DONE;
endmodule

// File: doc/booth_mult_seq.md
# booth_mult_seq

Parametrised, sequential radix-4 Booth multiplier. It is the successor to the team's combinational 8-bit radix-2 Booth multiplier and adds configurable operand width, signed/unsigned mode, and a start/busy/done handshake. It retires two multiplier bits per clock. It sits in the datapath wherever a multi-cycle multiply saves area over a fully combinational array.

## Interface
- `WIDTH`, default 8: operand width. Must be even and ≥4.
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request a multiply. Sampled only in IDLE or DONE.
- `abort`, input, 1: synchronous cancel of an operation in flight.
- `signed_mode`, input, 1: 1 means `a`/`b` are two's complement; 0 means unsigned. Sampled with `start`.
- `a`, input, WIDTH: multiplicand. Sampled with `start`.
- `b`, input, WIDTH: multiplier. Sampled with `start`.
- `busy`, output, 1: high while an operation is in flight.
- `done`, output, 1: one-cycle pulse when `product` is updated.
- `product`, output, 2*WIDTH: result. Two's complement if signed, else unsigned. Held until the next `done` or reset.

## Operation
- States: IDLE, RUN, DONE.
- Operand capture on accepted `start`:
  - `a` and `b` are extended to E = WIDTH+2 bits. Sign extension if `signed_mode`=1, zero extension otherwise.
  - The accumulator is cleared, the implicit bit q[-1] is set to 0, and the iteration counter is set to 0.
- Iteration count L = WIDTH/2+1. This is a fixed latency for both modes; the extra digit covers the unsigned MSB.
- Each RUN cycle:
  - Decode the 3-bit group {q[1], q[0], q[-1]} into a digit in {-2, -1, 0, +1, +2}.
  - Add digit×A to the upper accumulator. The add is E+1 bits wide so that ±2A does not overflow.
  - Arithmetic-shift the combined {acc, q, q[-1]} right by 2.
- After L iterations:
  - `product` takes the low 2*WIDTH bits of {acc, q}.
  - State goes to DONE.
- DONE lasts one cycle and `done`=1.
  - DONE goes to IDLE, or to RUN if `start`=1 (back-to-back accept).
- `start` while RUN is ignored. The in-flight operation is unaffected and no queueing occurs.
- `abort`=1 in RUN: go to IDLE next edge. `done` does not pulse and `product` is unchanged.
- `abort` and `start` together in IDLE or DONE: `abort` wins and `start` is dropped.
- `abort` in IDLE has no effect.
- Reset, asserted at any time including mid-RUN:
  - State IDLE.
  - `product`=0, `busy`=0, `done`=0.
  - Internal registers are cleared.
  - Nothing resumes after release.
- Width rules:
  - No overflow is possible. A full 2*WIDTH result is always produced.
  - Signed -2^(W-1) × -2^(W-1) = +2^(2W-2) must be exact.

## Timing
- Accept edge k: `start`=1 with state IDLE or DONE.
- `busy`=1 in the cycles after edges k … k+L-1. This is registered and decoded from RUN.
- The final iteration completes at edge k+L. `product` updates at that edge.
- `done`=1 for exactly the cycle after edge k+L, with `busy`=0 in the same cycle.
- For WIDTH=8, L=5. `done` is seen 5 clocks after the accept edge.
- Back-to-back throughput: one result per L+1 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package `booth_pkg` holds:
  - The state enum: IDLE, RUN, DONE.
  - The digit encoding type: {neg, one, two}.
  - A localparam function for L from WIDTH.
- Sub-module `booth_r4_encoder`: combinational 3-bit group to {neg, one, two}. It is instantiated once.
- Top-level `booth_mult_seq` contains:
  - The FSM.
  - The counter, sized $clog2(L+1).
  - The accumulator/shift register.
  - The product register.

## Test plan
- WIDTH=8, signed, a=-128, b=-128 → `done` after 5 clocks, `product`=0x4000.
- WIDTH=8, signed, a=127, b=-128 → `product`=0xC080 (-16256). Also a=0xFF, b=0xFF signed → 0x0001.
- WIDTH=8, unsigned, a=255, b=255 → `product`=0xFE01. Then a=0, b=200 → 0x0000.
- Mid-RUN behaviour:
  - Pulse `start` with new operands at cycle 2 of RUN → ignored, original result delivered.
  - `start` held high in DONE → next op accepted, second `done` 6 clocks after the first.
- Abort and reset:
  - `abort` in RUN cycle 3 → no `done`, `product` retains its old value, `busy`=0 next cycle.
  - `rst_n` low mid-RUN → `product`=0, `busy`=0 immediately (asynchronous).
- WIDTH=16 and WIDTH=4: random signed/unsigned operands against a reference multiply, 10k vectors, zero mismatches.
